dmem_responder: RTL and testbench
=================================

# dmem_responder

Multi-cycle data-memory responder for the MEM stage of the pipelined CPU. It accepts one load or store request at a time from the pipeline, holds it for a fixed access latency, then performs the access against an internal word array. It returns a one-cycle acknowledge with load data or an error flag, and raises a busy signal that the pipeline uses as its MEM-stage stall.

## Interface
- DEPTH, 32: number of 32-bit words in the array; power of two, at least 2.
- LATENCY, 2: wait cycles between request acceptance and response; at least 1.

- clk_i  in  1  single clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- req_i  in  1  request valid from the MEM stage; sampled only in IDLE.
- we_i  in  1  1 = store (sw), 0 = load (lw); sampled with req_i.
- addr_i  in  32  byte address; sampled with req_i.
- wdata_i  in  32  store data; sampled with req_i.
- busy_o  out  1  high while a request is in flight (WAIT and RESP); drives the pipeline stall.
- ack_o  out  1  one-cycle completion pulse.
- rdata_o  out  32  load result; valid when ack_o is high; held until the next ack.
- err_o  out  1  high with ack_o when the request was misaligned or out of range.

## Operation
- State machine: IDLE, WAIT, RESP.
- **IDLE:**
  - busy_o = 0, ack_o = 0.
  - If req_i = 1, latch we_i, addr_i and wdata_i, load the down-counter with LATENCY-1, and go to WAIT.
  - If req_i = 0, stay in IDLE.
- **WAIT:**
  - busy_o = 1.
  - While counter ≠ 0, decrement it.
  - When counter = 0, perform the access on that edge and go to RESP.
- **Access (on the WAIT→RESP edge):**
  - Word index = latched addr[log2(DEPTH)+1:2].
  - The request is an error if addr[1:0] ≠ 0, or if addr[31:2] ≥ DEPTH.
  - Error: no array write, rdata_o ← 0, err_o ← 1.
  - Valid store: array[index] ← wdata, rdata_o unchanged, err_o ← 0.
  - Valid load: rdata_o ← array[index], err_o ← 0.
- **RESP:**
  - ack_o = 1, busy_o = 1; go to IDLE unconditionally.
  - req_i is ignored in RESP. The pipeline must re-present any request after busy_o falls.
- req_i, we_i, addr_i and wdata_i are ignored outside IDLE. Latched values are used, so the requester need not hold them stable.
- Array contents are not reset and are undefined until written.
- A load immediately after a store to the same word returns the stored data.
- **Reset** (rst_i = 1 at an edge, any state):
  - Next state is IDLE; the counter is cleared.
  - busy_o, ack_o and err_o go to 0; rdata_o goes to 0.
  - Reset takes priority over req_i.
  - A store aborted in WAIT does not write the array.
  - The array is not cleared.

## Timing
- All outputs are registered or decoded from registered state; there is no combinational path from any input to any output.
- Reset values: busy_o = 0, ack_o = 0, err_o = 0, rdata_o = 32'h0.
- Cycle numbering: request presented in IDLE in cycle 0.
  - Cycles 1..LATENCY: WAIT, busy_o = 1.
  - Cycle LATENCY+1: RESP, ack_o = 1, busy_o = 1.
  - Cycle LATENCY+2: IDLE. The earliest next request is sampled here.
- Request-to-ack latency is LATENCY+1 cycles. Throughput is one request per LATENCY+2 cycles.
- ack_o is high for exactly one cycle per accepted request. err_o is high only in that same cycle.

## Test plan
- **Reset:** rst_i = 1 for 2 cycles with req_i = 1 → busy_o = ack_o = err_o = 0 and rdata_o = 0 throughout; no request accepted.
- **Store then load:**
  - Store 32'hDEADBEEF to 0x10 in cycle 0 (LATENCY = 2) → busy_o = 1 in cycles 1-3, ack_o = 1 only in cycle 3, err_o = 0.
  - Load 0x10 presented in cycle 4 → ack_o in cycle 7 with rdata_o = 32'hDEADBEEF, held after ack_o drops.
- **Error cases:**
  - Load at 0x12 (misaligned) → ack_o with err_o = 1 and rdata_o = 0.
  - Store at 0x80 with DEPTH = 32 (out of range) → err_o = 1, and a later load of 0x00 returns its previously written value.
- **Requests while busy:** req_i held high with changing addr_i in cycles 1-3 → ignored. Back-to-back requests complete one per 4 cycles; ack_o never lasts 2 consecutive cycles.
- **Reset mid-operation:** store 32'h12345678 to 0x04 over prior value 32'h0000AAAA, then rst_i pulsed in cycle 2 (WAIT) → no ack_o; a subsequent load of 0x04 returns 32'h0000AAAA.
- **Parameter sweep:** LATENCY = 1 and LATENCY = 5 → ack_o exactly 2 and 6 cycles after acceptance respectively.

Source files
------------

// File: rtl/dmem_responder_if.sv
// MEM-stage request/response bundle between pipeline and data memory.
// The pipeline drives requests and reads back busy/ack/data.
interface dmem_responder_if;
    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        busy_o;
    logic        ack_o;
    logic [31:0] rdata_o;
    logic        err_o;

    modport master (
        output req_i, we_i, addr_i, wdata_i,
        input  busy_o, ack_o, rdata_o, err_o
    );

    modport slave (
        input  req_i, we_i, addr_i, wdata_i,
        output busy_o, ack_o, rdata_o, err_o
    );
endinterface

// File: rtl/dmem_responder.sv
// Fixed-latency word memory for the MEM stage: one request in flight,
// one-cycle ack with load data or error, busy doubles as the stall.
module dmem_responder #(
    parameter int DEPTH   = 32,
    parameter int LATENCY = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    dmem_responder_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            err_q, err_d;
    logic            we_q;
    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;
    logic            latch_en;
    logic            mem_we;
    logic            acc_err;
    logic [AW-1:0]   idx;
    logic [31:0]     mem [DEPTH];

    assign idx     = addr_q[AW+1:2];
    assign acc_err = (addr_q[1:0] != 2'b00) || (|addr_q[31:AW+2]);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        err_d    = 1'b0;
        latch_en = 1'b0;
        mem_we   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.req_i) begin
                    latch_en = 1'b1;
                    cnt_d    = CW'(LATENCY - 1);
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    state_d = RESP;
                    if (acc_err) begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                    end else if (we_q) begin
                        mem_we = 1'b1;
                    end else begin
                        rdata_d = mem[idx];
                    end
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (latch_en) begin
            we_q    <= bus.we_i;
            addr_q  <= bus.addr_i;
            wdata_q <= bus.wdata_i;
        end
    end

    // Reset overrides the access edge, so an aborted store never lands
    always_ff @(posedge clk_i) begin
        if (!rst_i && mem_we) begin
            mem[idx] <= wdata_q;
        end
    end

    assign bus.busy_o  = (state_q != IDLE);
    assign bus.ack_o   = (state_q == RESP);
    assign bus.rdata_o = rdata_q;
    assign bus.err_o   = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three latencies share one stimulus stream,
// each checked every cycle against a transaction-level model.
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;

    int pass_cnt = 0;
    int total_cnt = 0;

    dmem_responder_if b1 ();
    dmem_responder_if b2 ();
    dmem_responder_if b5 ();

    assign b1.req_i = req;  assign b1.we_i = we;
    assign b1.addr_i = addr; assign b1.wdata_i = wdata;
    assign b2.req_i = req;  assign b2.we_i = we;
    assign b2.addr_i = addr; assign b2.wdata_i = wdata;
    assign b5.req_i = req;  assign b5.we_i = we;
    assign b5.addr_i = addr; assign b5.wdata_i = wdata;

    dmem_responder #(.DEPTH(32), .LATENCY(1)) u1 (
        .clk_i(clk), .rst_i(rst), .bus(b1));
    dmem_responder #(.DEPTH(32), .LATENCY(2)) u2 (
        .clk_i(clk), .rst_i(rst), .bus(b2));
    dmem_responder #(.DEPTH(32), .LATENCY(5)) u5 (
        .clk_i(clk), .rst_i(rst), .bus(b5));

    always #5 clk = ~clk;

    logic        busy_a [3];
    logic        ack_a  [3];
    logic        err_a  [3];
    logic [31:0] rd_a   [3];
    assign busy_a[0] = b1.busy_o; assign ack_a[0] = b1.ack_o;
    assign err_a[0] = b1.err_o;   assign rd_a[0] = b1.rdata_o;
    assign busy_a[1] = b2.busy_o; assign ack_a[1] = b2.ack_o;
    assign err_a[1] = b2.err_o;   assign rd_a[1] = b2.rdata_o;
    assign busy_a[2] = b5.busy_o; assign ack_a[2] = b5.ack_o;
    assign err_a[2] = b5.err_o;   assign rd_a[2] = b5.rdata_o;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Transaction-level model: age of the in-flight request in cycles
    int          lat [3] = '{1, 2, 5};
    bit          en = 1'b0;
    bit          pend [3];
    int          age  [3];
    bit          lwe  [3];
    logic [31:0] ladr [3];
    logic [31:0] lwd  [3];
    logic [31:0] mmem [3][32];
    bit          known [3][32];
    logic [31:0] erd  [3];
    bit          erdk [3];
    bit          eerr [3];

    always @(posedge clk) begin
        if (rst) en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                pend[k] = 1'b0;
                erd[k]  = '0;
                erdk[k] = 1'b1;
                eerr[k] = 1'b0;
            end else if (!pend[k]) begin
                if (req) begin
                    pend[k] = 1'b1;
                    age[k]  = 1;
                    lwe[k]  = we;
                    ladr[k] = addr;
                    lwd[k]  = wdata;
                end
            end else begin
                age[k]++;
                if (age[k] == lat[k] + 1) begin
                    if (ladr[k][1:0] != 0 || ladr[k][31:2] >= 32) begin
                        erd[k]  = '0;
                        erdk[k] = 1'b1;
                        eerr[k] = 1'b1;
                    end else if (lwe[k]) begin
                        mmem[k][ladr[k][6:2]]  = lwd[k];
                        known[k][ladr[k][6:2]] = 1'b1;
                        eerr[k] = 1'b0;
                    end else begin
                        erd[k]  = mmem[k][ladr[k][6:2]];
                        erdk[k] = known[k][ladr[k][6:2]];
                        eerr[k] = 1'b0;
                    end
                end else if (age[k] == lat[k] + 2) begin
                    pend[k] = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (en) begin
            for (int k = 0; k < 3; k++) begin
                bit eack;
                eack = pend[k] && (age[k] == lat[k] + 1);
                chk($sformatf("busy L%0d", lat[k]), 32'(busy_a[k]), 32'(pend[k]));
                chk($sformatf("ack L%0d", lat[k]), 32'(ack_a[k]), 32'(eack));
                chk($sformatf("err L%0d", lat[k]), 32'(err_a[k]),
                    32'(eack && eerr[k]));
                if (erdk[k])
                    chk($sformatf("rdata L%0d", lat[k]), rd_a[k], erd[k]);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic settle(input int n);
        repeat (n) tick();
    endtask

    // Isolated request; literal check of the LATENCY=2 ack in cycle 3
    task automatic req_u2(input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic xerr,
                          input logic [31:0] xrd, input string nm);
        req = 1'b1; we = w; addr = a; wdata = d;
        tick();
        req = 1'b0;
        tick();
        tick();
        chk({nm, " ack"}, 32'(b2.ack_o), 32'd1);
        chk({nm, " err"}, 32'(b2.err_o), 32'(xerr));
        chk({nm, " rdata"}, b2.rdata_o, xrd);
        settle(6);
    endtask

    initial begin
        rst = 1'b1; req = 1'b1; we = 1'b1;
        addr = 32'h0; wdata = 32'h1111_1111;
        settle(2);
        chk("rst busy", 32'(b2.busy_o), 32'd0);
        chk("rst rdata", b2.rdata_o, 32'd0);
        rst = 1'b0; req = 1'b0;
        settle(2);

        // store DEADBEEF @0x10, then load it back in cycle 4
        req = 1'b1; we = 1'b1; addr = 32'h10; wdata = 32'hDEADBEEF;
        tick();
        req = 1'b0; addr = 32'h44;
        chk("st c1 busy", 32'(b2.busy_o), 32'd1);
        tick();
        chk("st c2 ack", 32'(b2.ack_o), 32'd0);
        chk("L1 ack at +2", 32'(b1.ack_o), 32'd1);
        tick();
        chk("st c3 ack", 32'(b2.ack_o), 32'd1);
        tick();
        chk("st c4 busy", 32'(b2.busy_o), 32'd0);
        req = 1'b1; we = 1'b0; addr = 32'h10;
        tick();
        req = 1'b0;
        tick();
        chk("L5 ack at +6", 32'(b5.ack_o), 32'd1);
        tick();
        chk("ld c7 ack", 32'(b2.ack_o), 32'd1);
        chk("ld c7 rdata", b2.rdata_o, 32'hDEADBEEF);
        tick();
        chk("ld c8 ack", 32'(b2.ack_o), 32'd0);
        chk("ld c8 hold", b2.rdata_o, 32'hDEADBEEF);
        settle(6);

        req_u2(1'b1, 32'h00, 32'h0000C0DE, 1'b0, 32'hDEADBEEF, "st0");
        req_u2(1'b0, 32'h12, 32'h0, 1'b1, 32'h0, "misal");
        req_u2(1'b1, 32'h80, 32'h5555_5555, 1'b1, 32'h0, "oor");
        req_u2(1'b0, 32'h00, 32'h0, 1'b0, 32'h0000C0DE, "ld0");
        req_u2(1'b1, 32'h04, 32'h0000AAAA, 1'b0, 32'h0000C0DE, "stA");

        // store aborted by reset on its access edge
        req = 1'b1; we = 1'b1; addr = 32'h04; wdata = 32'h12345678;
        tick();
        req = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort ack", 32'(b2.ack_o), 32'd0);
        chk("abort busy", 32'(b2.busy_o), 32'd0);
        settle(7);
        req_u2(1'b0, 32'h04, 32'h0, 1'b0, 32'h0000AAAA, "ldA");

        // request held high while busy with changing address
        for (int i = 0; i < 16; i++) begin
            req = 1'b1; we = 1'($urandom);
            addr = {$urandom_range(0, 31), 2'b00};
            wdata = $urandom;
            tick();
        end
        req = 1'b0;
        settle(8);

        for (int i = 0; i < 3000; i++) begin
            int sel;
            rst = ($urandom_range(0, 99) == 0);
            req = 1'($urandom);
            we = ($urandom_range(0, 2) != 0);
            sel = $urandom_range(0, 19);
            if (sel == 0) addr = $urandom;
            else if (sel == 1) addr = {$urandom_range(0, 31), 2'($urandom_range(1, 3))};
            else addr = {$urandom_range(0, 39), 2'b00};
            wdata = $urandom;
            tick();
        end
        rst = 1'b0; req = 1'b0;
        settle(10);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
